reg_file_param: RTL and testbench

Parametrised multi-port register file, successor to the lab's 8x16 two-read/one-write register file. Adds configurable width, depth, number of write ports and read ports, internal write-to-read bypass, per-port write byte-enables, and a busy/done sequenced clear engine. Sits in the datapath between decode and ALU.

---
 rtl/reg_file_pkg.sv | 28 ++
 rtl/reg_file_clr_fsm.sv | 57 +++++
 rtl/reg_file_param.sv | 81 ++++++++
 tb/tb_reg_file_param.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the parameterised register file.
// Optional registered-read mode is selected by REG_FILE_RDREG_EN.
package reg_file_pkg;

    localparam int BYTE_W = 8;
    localparam int MAX_W  = 256;
    localparam int MAX_BE = MAX_W / BYTE_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

    // Operates on the widest supported word; callers zero-extend and truncate.
    function automatic logic [MAX_W-1:0] byte_merge(
        input logic [MAX_W-1:0]  old_val,
        input logic [MAX_W-1:0]  new_val,
        input logic [MAX_BE-1:0] be
    );
        logic [MAX_W-1:0] res;
        res = old_val;
        for (int b = 0; b < MAX_BE; b++)
            if (be[b]) res[b*BYTE_W +: BYTE_W] = new_val[b*BYTE_W +: BYTE_W];
        return res;
    endfunction

endpackage

// File: rtl/reg_file_clr_fsm.sv
// Sequenced clear engine: zeroes one register per cycle, then pulses clr_done.
module reg_file_clr_fsm
    import reg_file_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    clr_state_t        state;
    logic [ADDR_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    clr_done <= 1'b0;
                    if (clr_req) begin
                        state    <= CLEAR;
                        cnt      <= '0;
                        clr_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == ADDR_W'(DEPTH - 1)) begin
                        state    <= DONE;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                    end
                end
                DONE: begin
                    clr_done <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // busy is high exactly while in CLEAR, so it doubles as the clear strobe
    assign clr_we   = clr_busy;
    assign clr_addr = cnt;

endmodule

// File: rtl/reg_file_param.sv
// Multi-port register file with byte enables and a sequenced clear engine.
// Define REG_FILE_RDREG_EN for registered reads with write-to-read bypass.
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int BE_W   = DATA_W / BYTE_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_WR-1:0]        wr,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*BE_W-1:0]   wr_be,
    input  logic [NUM_WR*DATA_W-1:0] d_in,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] d_out,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done
);

    logic [DEPTH-1:0][DATA_W-1:0] mem, mem_nxt;
    logic                         clr_we;
    logic [ADDR_W-1:0]            clr_addr;

    reg_file_clr_fsm #(.DEPTH(DEPTH)) u_clr (
        .clk      (clk),
        .reset    (reset),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Ports are applied in order on a running copy, so port 1 wins per byte
    // while non-overlapping bytes from both ports merge.
    always_comb begin
        logic [ADDR_W-1:0] wa;
        wa      = '0;
        mem_nxt = mem;
        if (clr_we) begin
            mem_nxt[clr_addr] = '0;
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr[p]) begin
                    wa          = wr_addr[p*ADDR_W +: ADDR_W];
                    mem_nxt[wa] = DATA_W'(byte_merge(MAX_W'(mem_nxt[wa]),
                                                     MAX_W'(d_in[p*DATA_W +: DATA_W]),
                                                     MAX_BE'(wr_be[p*BE_W +: BE_W])));
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) mem <= '0;
        else       mem <= mem_nxt;
    end

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] q;
        assign ra = rd_addr[r*ADDR_W +: ADDR_W];
`ifdef REG_FILE_RDREG_EN
        // Sampling the next-state array gives the bypass for free.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) q <= '0;
            else       q <= mem_nxt[ra];
        end
`else
        assign q = mem[ra];
`endif
        assign d_out[r*DATA_W +: DATA_W] = q;
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param (default 16-bit, 8 deep, 2R/2W).
module tb_reg_file_param;

    logic        clk, reset;
    logic [1:0]  wr;
    logic [5:0]  wr_addr;
    logic [3:0]  wr_be;
    logic [31:0] d_in;
    logic [5:0]  rd_addr;
    logic [31:0] d_out;
    logic        clr_req, clr_busy, clr_done;

    int checks = 0;
    int errors = 0;
    int busy_cnt, done_cnt;

    reg_file_param dut (
        .clk      (clk),
        .reset    (reset),
        .wr       (wr),
        .wr_addr  (wr_addr),
        .wr_be    (wr_be),
        .d_in     (d_in),
        .rd_addr  (rd_addr),
        .d_out    (d_out),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
`ifdef REG_FILE_RDREG_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
    endtask

    initial begin
        reset = 1'b1; wr = '0; wr_addr = '0; wr_be = '0; d_in = '0;
        rd_addr = '0; clr_req = 1'b0;

        #35;
        chk("rst_dout", 64'(d_out), 64'h0);
        chk("rst_busy", 64'(clr_busy), 64'h0);
        chk("rst_done", 64'(clr_done), 64'h0);
        #5 reset = 1'b0;
        tick;

        // both ports, different registers
        wr = 2'b11; wr_addr = {3'd1, 3'd0}; wr_be = 4'hF; d_in = {16'h5678, 16'h1234};
        tick;
        wr = '0; rd_addr = {3'd1, 3'd0};
        settle;
        chk("dual_write", 64'(d_out), 64'h5678_1234);

`ifndef REG_FILE_RDREG_EN
        // pending write must not show before the edge
        wr = 2'b01; wr_addr = {3'd0, 3'd0}; wr_be = 4'h3; d_in = {16'h0, 16'hFFFF};
        rd_addr = {3'd0, 3'd0};
        #1 chk("no_bypass", 64'(d_out[15:0]), 64'h1234);
        tick;
        wr = '0;
        #1 chk("post_edge", 64'(d_out[15:0]), 64'hFFFF);
`endif

        // same register, byte merge with port 1 priority
        wr = 2'b11; wr_addr = {3'd2, 3'd2}; wr_be = {2'b01, 2'b11}; d_in = {16'hBBCC, 16'hAAAA};
        tick;
        wr = '0; rd_addr = {3'd0, 3'd2};
        settle;
        chk("merge_r2", 64'(d_out[15:0]), 64'hAACC);

        // partial byte update
        wr = 2'b01; wr_addr = {3'd0, 3'd3}; wr_be = 4'h3; d_in = {16'h0, 16'h9ABC};
        tick;
        wr_be = 4'h2; d_in = {16'h0, 16'hDEF0};
        tick;
        wr = '0; rd_addr = {3'd0, 3'd3};
        settle;
        chk("be_r3", 64'(d_out[15:0]), 64'hDEBC);

        // fill all registers
        for (int i = 0; i < 8; i++) begin
            wr = 2'b01; wr_addr = {3'd0, 3'(i)}; wr_be = 4'h3;
            d_in = {16'h0, 16'(16'h1111 * (i + 1))};
            tick;
        end
        wr = '0; rd_addr = {3'd7, 3'd6};
        settle;
        chk("fill_r7_r6", 64'(d_out), 64'h8888_7777);

        // sequenced clear, with a dropped write to r0 mid-clear
        clr_req = 1'b1;
        tick;
        clr_req = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (clr_busy) busy_cnt++;
            if (clr_done) done_cnt++;
            wr = (busy_cnt == 3) ? 2'b01 : 2'b00;
            wr_addr = {3'd0, 3'd0}; wr_be = 4'h3; d_in = {16'h0, 16'hBEEF};
            tick;
        end
        wr = '0;
        chk("busy_cycles", 64'(busy_cnt), 64'd8);
        chk("done_pulses", 64'(done_cnt), 64'd1);
        for (int i = 0; i < 8; i++) begin
            rd_addr = {3'(i), 3'(i)};
            settle;
            chk($sformatf("cleared_r%0d", i), 64'(d_out), 64'h0);
        end
        rd_addr = {3'd0, 3'd0};
        settle;
        chk("dropped_wr_r0", 64'(d_out[15:0]), 64'h0);

        // reset mid-clear at cnt=3
        wr = 2'b01; wr_addr = {3'd0, 3'd5}; wr_be = 4'h3; d_in = {16'h0, 16'h5555};
        tick;
        wr = '0; clr_req = 1'b1;
        tick;
        clr_req = 1'b0;
        tick; tick; tick;
        chk("busy_before_rst", 64'(clr_busy), 64'h1);
        reset = 1'b1;
        #1;
        chk("midclr_busy", 64'(clr_busy), 64'h0);
        chk("midclr_done", 64'(clr_done), 64'h0);
        for (int i = 0; i < 8; i++) begin
            rd_addr = {3'(i), 3'(i)};
            #1 chk($sformatf("midclr_r%0d", i), 64'(d_out), 64'h0);
        end
        reset = 1'b0;
        tick; tick;
        chk("idle_after_rst", 64'(clr_busy), 64'h0);
        rd_addr = {3'd0, 3'd5};
        settle;
        chk("r5_after_rst", 64'(d_out[15:0]), 64'h0);

`ifdef REG_FILE_RDREG_EN
        // write-to-read bypass into the registered output
        wr = 2'b01; wr_addr = {3'd0, 3'd4}; wr_be = 4'h3; d_in = {16'h0, 16'h1111};
        rd_addr = {3'd0, 3'd4};
        tick;
        wr = '0;
        chk("rdreg_bypass", 64'(d_out[15:0]), 64'h1111);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
